// File: rtl/jtag_master_pkg.sv
// Shared types and TAP navigation constants for the jtag_master scan engine.
// Sequence vectors are read LSB first: bit i is the tms value driven for rising edge i.
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_RESET    = 2'b00,
        OP_IR_SCAN  = 2'b01,
        OP_DR_SCAN  = 2'b10,
        OP_RUN_IDLE = 2'b11
    } jtag_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RSP
    } jtag_state_e;

    // Five ones reach Test-Logic-Reset from any TAP state; the trailing zero parks in Run-Test/Idle.
    localparam int         PRE_RESET_LEN = 6;
    localparam logic [7:0] PRE_RESET_TMS = 8'b0001_1111;

    // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam int         PRE_IR_LEN    = 4;
    localparam logic [7:0] PRE_IR_TMS    = 8'b0000_0011;

    // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam int         PRE_DR_LEN    = 3;
    localparam logic [7:0] PRE_DR_TMS    = 8'b0000_0001;

    // Exit1 -> Update -> Run-Test/Idle
    localparam int         POST_LEN      = 2;
    localparam logic [1:0] POST_TMS      = 2'b01;

    function automatic logic [2:0] pre_len(input jtag_op_e op);
        case (op)
            OP_RESET:   return 3'(PRE_RESET_LEN);
            OP_IR_SCAN: return 3'(PRE_IR_LEN);
            OP_DR_SCAN: return 3'(PRE_DR_LEN);
            default:    return 3'd0;
        endcase
    endfunction

    // RUN_IDLE holds tms low for its whole preamble, so its pattern is all zeros.
    function automatic logic [7:0] pre_tms(input jtag_op_e op);
        case (op)
            OP_RESET:   return PRE_RESET_TMS;
            OP_IR_SCAN: return PRE_IR_TMS;
            OP_DR_SCAN: return PRE_DR_TMS;
            default:    return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// Divides clk into tck with a half-period of CLK_DIV cycles; tck_rise/tck_fall flag the
// clk cycle in which tck toggles. Dropping en forces tck low and restarts the count.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);
    localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             tck_reg;
    logic             wrap;

    assign wrap     = en && (cnt_reg == CNT_MAX);
    assign tck_rise = wrap && !tck_reg;
    assign tck_fall = wrap && tck_reg;
    assign tck      = tck_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            tck_reg <= 1'b0;
        end else if (!en) begin
            cnt_reg <= '0;
            tck_reg <= 1'b0;
        end else if (wrap) begin
            cnt_reg <= '0;
            tck_reg <= ~tck_reg;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jtag_master.sv
// Command-driven JTAG scan engine: walks the TAP from Run-Test/Idle, shifts tdi, captures tdo.
// Optional macro JTAG_TRST_EN adds an active-high trst output held for the whole RESET op.
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 6,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
`ifdef JTAG_TRST_EN
   ,output logic              trst
`endif
);
    // One extra bit so a full-width scan (DATA_W rising edges) can be counted.
    localparam int                IDX_W    = LEN_W + 1;
    localparam int                TAIL_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TAIL_W-1:0] TAIL_MAX = TAIL_W'(CLK_DIV - 1);

    jtag_state_e       state_reg;
    jtag_op_e          op_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [DATA_W-1:0] data_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              tail_reg;
    logic [TAIL_W-1:0] tail_cnt_reg;
    logic              run_reg;
    logic              tms_reg;
    logic              tdi_reg;
    logic              cmd_ready_reg;
    logic              rsp_valid_reg;
`ifdef JTAG_TRST_EN
    logic              trst_reg;
`endif

    logic              tck_rise;
    logic              tck_fall;
    logic              accept;
    logic              shift_rise;
    logic [7:0]        acc_seq;
    logic [7:0]        pre_seq;
    logic [IDX_W-1:0]  len_ext;
    logic [IDX_W-1:0]  idx_inc;
    logic [IDX_W-1:0]  pre_n;
    logic [DATA_W-1:0] cap_bits;

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run_reg),
        .tck      (tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    assign accept     = cmd_ready_reg && cmd_valid;
    assign shift_rise = (state_reg == ST_SHIFT) && tck_rise;
    assign acc_seq    = pre_tms(jtag_op_e'(cmd_op));
    assign pre_seq    = pre_tms(op_reg);
    assign len_ext    = {1'b0, len_reg};
    assign idx_inc    = idx_reg + IDX_W'(1);
    assign pre_n      = (op_reg == OP_RUN_IDLE) ? len_ext + IDX_W'(1)
                                                : IDX_W'(pre_len(op_reg));

    // Each capture bit owns its flop; idx_reg selects which one takes tdo on a shift edge.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_cap
            logic bit_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    bit_reg <= 1'b0;
                else if (accept)
                    bit_reg <= 1'b0;
                else if (shift_rise && (idx_reg == IDX_W'(gi)))
                    bit_reg <= tdo;
            end
            assign cap_bits[gi] = bit_reg;
        end
    endgenerate

    // Rising edges only count; every tms/tdi decision is taken on the falling edge that follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_RESET;
            len_reg       <= '0;
            data_reg      <= '0;
            idx_reg       <= '0;
            tail_reg      <= 1'b0;
            tail_cnt_reg  <= '0;
            run_reg       <= 1'b0;
            tms_reg       <= 1'b1;
            tdi_reg       <= 1'b0;
            cmd_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
`ifdef JTAG_TRST_EN
            trst_reg      <= 1'b0;
`endif
        end else if (tail_reg) begin
            // Final low half-period with tck parked before the response is offered.
            if (tail_cnt_reg == TAIL_MAX) begin
                tail_reg      <= 1'b0;
                state_reg     <= ST_RSP;
                rsp_valid_reg <= 1'b1;
`ifdef JTAG_TRST_EN
                trst_reg      <= 1'b0;
`endif
            end else begin
                tail_cnt_reg <= tail_cnt_reg + TAIL_W'(1);
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg     <= ST_PRE;
                        op_reg        <= jtag_op_e'(cmd_op);
                        len_reg       <= cmd_len;
                        data_reg      <= cmd_data;
                        idx_reg       <= '0;
                        run_reg       <= 1'b1;
                        tms_reg       <= acc_seq[0];
                        tdi_reg       <= 1'b0;
                        cmd_ready_reg <= 1'b0;
`ifdef JTAG_TRST_EN
                        trst_reg      <= (cmd_op == OP_RESET);
`endif
                    end
                end

                ST_PRE: begin
                    if (tck_rise) begin
                        idx_reg <= idx_inc;
                    end else if (tck_fall) begin
                        if (idx_reg < pre_n) begin
                            tms_reg <= pre_seq[idx_reg[2:0]];
                        end else if (op_reg == OP_IR_SCAN || op_reg == OP_DR_SCAN) begin
                            state_reg <= ST_SHIFT;
                            idx_reg   <= '0;
                            tdi_reg   <= data_reg[0];
                            tms_reg   <= (len_reg == '0);
                        end else begin
                            tail_reg     <= 1'b1;
                            tail_cnt_reg <= '0;
                            run_reg      <= 1'b0;
                            tms_reg      <= 1'b0;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (tck_rise) begin
                        idx_reg <= idx_inc;
                    end else if (tck_fall) begin
                        if (idx_reg <= len_ext) begin
                            tdi_reg <= data_reg[idx_reg[LEN_W-1:0]];
                            tms_reg <= (idx_reg == len_ext);
                        end else begin
                            state_reg <= ST_POST;
                            idx_reg   <= '0;
                            tdi_reg   <= 1'b0;
                            tms_reg   <= POST_TMS[0];
                        end
                    end
                end

                ST_POST: begin
                    if (tck_rise) begin
                        idx_reg <= idx_inc;
                    end else if (tck_fall) begin
                        if (idx_reg < IDX_W'(POST_LEN)) begin
                            tms_reg <= POST_TMS[idx_reg[0]];
                        end else begin
                            tail_reg     <= 1'b1;
                            tail_cnt_reg <= '0;
                            run_reg      <= 1'b0;
                            tms_reg      <= 1'b0;
                        end
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = cap_bits;
    assign tms       = tms_reg;
    assign tdi       = tdi_reg;
`ifdef JTAG_TRST_EN
    assign trst      = trst_reg;
`endif

endmodule

// File: tb/tb_jtag_master.sv
// Directed and randomized scans against a behavioural IEEE 1149.1 TAP with a 4-bit IR and
// a 1-bit BYPASS data register; expectations come from the command rules, not the RTL.
module tb_jtag_master;
    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_len = 6'd0;
    logic [63:0] cmd_data = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo = 1'b0;

    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    jtag_master #(
        .DATA_W  (64),
        .LEN_W   (6),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    // ---------------- TAP model ----------------
    typedef enum int {TLR, RTI, SDS, CDR, SDR, E1D, PDR, E2D, UDR,
                      SIS, CIR, SIR, E1I, PIR, E2I, UIR} tap_e;

    tap_e       tap_st = PIR;
    logic       dr_sr = 1'b0;
    logic [3:0] ir_sr = 4'd0;
    logic [3:0] ir = 4'b0001;
    bit         tms_q[$];
    bit         exp_q[$];

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDS : RTI;
            SDS: return m ? SIS : CDR;
            CDR: return m ? E1D : SDR;
            SDR: return m ? E1D : SDR;
            E1D: return m ? UDR : PDR;
            PDR: return m ? E2D : PDR;
            E2D: return m ? UDR : SDR;
            UDR: return m ? SDS : RTI;
            SIS: return m ? TLR : CIR;
            CIR: return m ? E1I : SIR;
            SIR: return m ? E1I : SIR;
            E1I: return m ? UIR : PIR;
            PIR: return m ? E2I : PIR;
            E2I: return m ? UIR : SIR;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        tms_q.push_back(tms);
        case (tap_st)
            TLR: ir <= 4'b0001;
            CDR: dr_sr <= 1'b0;
            SDR: dr_sr <= tdi;
            CIR: ir_sr <= 4'b0001;
            SIR: ir_sr <= {tdi, ir_sr[3:1]};
            UIR: ir <= ir_sr;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
    end

    always @(negedge tck)
        tdo <= (tap_st == SDR) ? dr_sr : ((tap_st == SIR) ? ir_sr[0] : 1'b0);

    // ---------------- reference helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int n);
        return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    endfunction

    // Expected tms value at every tck rise, from the TAP walk each op must perform.
    task automatic build_exp(input logic [1:0] op, input int n);
        exp_q.delete();
        case (op)
            2'b00: begin
                repeat (5) exp_q.push_back(1'b1);
                exp_q.push_back(1'b0);
            end
            2'b11: repeat (n) exp_q.push_back(1'b0);
            default: begin
                exp_q.push_back(1'b1);
                if (op == 2'b01) exp_q.push_back(1'b1);
                exp_q.push_back(1'b0);
                exp_q.push_back(1'b0);
                for (int i = 0; i < n; i++) exp_q.push_back(i == n - 1);
                exp_q.push_back(1'b1);
                exp_q.push_back(1'b0);
            end
        endcase
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [63:0] data,
                           input logic [63:0] exp_rsp, input int hold, input string tag);
        int n;
        int cyc;
        int mism;
        n = int'(len) + 1;
        build_exp(op, n);

        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        check({tag, " cmd_ready"}, cmd_ready, 1);

        tms_q.delete();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_len   = ~len;
        cmd_data  = ~data;

        cyc = 0;
        while (tck !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        check({tag, " first_rise"}, cyc, CLK_DIV);

        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
        check({tag, " rsp_valid"}, rsp_valid, 1);
        check({tag, " rsp_data"}, rsp_data, exp_rsp);
        check({tag, " idle_lines"}, {tck, tms, cmd_ready}, 3'b000);
        check({tag, " tms_count"}, tms_q.size(), exp_q.size());
        mism = -1;
        for (int i = 0; i < tms_q.size() && i < exp_q.size(); i++)
            if (mism < 0 && tms_q[i] != exp_q[i]) mism = i;
        check({tag, " tms_seq_first_bad"}, mism, -1);

        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'b11;
            cmd_len   = 6'd0;
            check({tag, " hold_valid"}, rsp_valid, 1);
            check({tag, " hold_data"}, rsp_data, exp_rsp);
            check({tag, " hold_ready_tck"}, {cmd_ready, tck}, 2'b00);
            @(negedge clk);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " after_handshake"}, {rsp_valid, cmd_ready}, 2'b01);
        cmd_valid = 1'b0;
        check({tag, " tap_in_rti"}, tap_st, RTI);
        $display("txn %s op=%0d len=%0d data=%h rsp=%h", tag, op, len, data, rsp_data);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          cyc;
        int          seen;
        int unsigned sel;
        logic [5:0]  len;
        logic [63:0] d;
        int          n;

        repeat (3) @(negedge clk);
        check("in_reset", {tck, tms, tdi, cmd_ready, rsp_valid}, 5'b01010);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", {tck, tms, tdi, cmd_ready, rsp_valid}, 5'b01010);
        check("reset_rsp_data", rsp_data, 64'd0);

        run_cmd(2'b00, 6'd0, 64'd0, 64'd0, 0, "reset");
        run_cmd(2'b01, 6'd3, 64'hA, 64'h1, 0, "ir_scan");
        check("ir_update", ir, 4'b1010);
        run_cmd(2'b10, 6'd63, 64'hDEADBEEF01234567, 64'hBD5B7DDE02468ACE, 10, "dr_bypass");

        for (int t = 0; t < 8; t++) begin
            sel = $urandom_range(0, 2);
            d   = {$urandom, $urandom};
            case (sel)
                0: begin
                    len = 6'($urandom_range(0, 63));
                    n   = int'(len) + 1;
                    run_cmd(2'b10, len, d, (d << 1) & mask(n), 0, "rand_dr");
                end
                1: begin
                    len = 6'($urandom_range(3, 20));
                    n   = int'(len) + 1;
                    run_cmd(2'b01, len, d, ((d << 4) | 64'd1) & mask(n), 0, "rand_ir");
                    check("rand_ir_update", ir, 4'((d >> (n - 4)) & 64'hF));
                end
                default: begin
                    len = 6'($urandom_range(0, 15));
                    run_cmd(2'b11, len, d, 64'd0, 0, "rand_idle");
                end
            endcase
        end

        // Abort a full-width scan part-way through the shift.
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        tms_q.delete();
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_len   = 6'd63;
        cmd_data  = {$urandom, $urandom};
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (tms_q.size() < 24 && cyc < 2000) begin @(negedge clk); cyc++; end
        check("abort_reached_bit20", tms_q.size(), 24);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", {tck, tms, tdi, cmd_ready, rsp_valid}, 5'b01010);
        check("abort_rsp_data", rsp_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
            if (tck !== 1'b0) seen++;
        end
        check("abort_quiet", seen, 0);
        $display("txn abort rst_n pulsed during shift bit 20");

        run_cmd(2'b00, 6'd0, 64'd0, 64'd0, 0, "reset_after_abort");
        d = {$urandom, $urandom};
        run_cmd(2'b10, 6'd40, d, (d << 1) & mask(41), 0, "dr_after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
